sw_align_engine: RTL and testbench
==================================

Name: sw_align_engine

Overview:
Parametrised, multi-cycle Smith-Waterman local aligner and successor of the single-cycle aligner. It has runtime-programmable scoring, a valid/ready start and result handshake, and saturating fixed-width scores. Gaps are reported through explicit gap masks instead of X codes. It computes one score cell per cycle, stores only 2-bit traceback directions plus two score row buffers, then walks the traceback one pair per cycle.

Parameters:
REF_LEN, 15, reference length in bases
QUERY_LEN, 10, query length in bases
BASE_WIDTH, 2, bits per base (A=00, T=01, G=10, C=11)
SCORE_W, 8, signed score width; positive saturation limit 2^(SCORE_W-1)-1
ALIGN_LEN, REF_LEN+QUERY_LEN, maximum number of aligned pairs

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start_valid  in  1  job request
start_ready  out  1  high only in IDLE
ref_seq  in  REF_LEN*BASE_WIDTH  base 0 at MSBs
query_seq  in  QUERY_LEN*BASE_WIDTH  base 0 at MSBs
match_score, mismatch_score, gap_score  in  SCORE_W signed  scoring values, latched at start
result_valid  out  1  result held stable until accepted
result_ready  in  1  result consumer ready
aligned_ref_seq, aligned_query_seq  out  ALIGN_LEN*BASE_WIDTH  pair k at bits [k*BASE_WIDTH +: BASE_WIDTH]; k=0 is the alignment end
ref_gap_mask, query_gap_mask  out  ALIGN_LEN  bit k set means side k is a gap; the base field is then 0
alignment_length  out  8  number of valid pairs
max_score  out  SCORE_W  best cell score (non-negative)
ref_end, query_end  out  8  1-based cell of the maximum; 0 if max_score=0
busy  out  1  high in FILL or TRACE

Behaviour:
- Reset (synchronous, wins over everything, including mid-job):
  - state returns to IDLE; the job in flight is discarded.
  - all outputs go to 0; start_ready goes to 1.
- Handshake and latching:
  - start is accepted when start_valid && start_ready, at cycle T.
  - sequences and scores are latched at T; later input changes have no effect.
  - start_valid in any other state is ignored and is not queued.
- FSM: IDLE -> FILL -> TRACE -> DONE -> IDLE.
- FILL:
  - row-major over i=1..REF_LEN, j=1..QUERY_LEN; one cell per cycle; lasts REF_LEN*QUERY_LEN cycles (cycles T+1..T+R*Q).
  - row 0 and column 0 are 0.
  - diag = H[i-1][j-1] + (ref[i-1]==query[j-1] ? match : mismatch); up = H[i-1][j] + gap; left = H[i][j-1] + gap.
  - selection: start with diag; replace with up only if strictly greater, then with left only if strictly greater.
  - if the result <= 0: H=0 and dir=STOP. Otherwise dir = DIAG, UP or LEFT.
  - arithmetic in SCORE_W+2 bits; saturate at 2^(SCORE_W-1)-1.
  - the maximum updates only on a strictly greater score, so the first cell in row-major order wins ties.
- TRACE:
  - starts at (ref_end, query_end); emits one pair per cycle.
  - DIAG: i--, j--. UP: ref base paired with a query gap, i--. LEFT: ref gap paired with a query base, j--.
  - stops on STOP, i==0, j==0, or alignment_length==ALIGN_LEN; the stop check takes 1 cycle.
  - trace duration is L+1 cycles, where L = final alignment_length.
  - if max_score==0: L=0, and TRACE takes 1 cycle.
- DONE:
  - result_valid rises at cycle T+R*Q+L+2; all result outputs stay stable while result_ready is low.
  - on result_valid && result_ready: result_valid falls the next cycle and the FSM returns to IDLE.
  - results stay visible until the next accepted start clears them.
- Unused pair slots (k >= L) are 0 in all four result vectors and masks.

Decomposition:
- sw_pkg holds:
  - direction codes: STOP=0, DIAG=1, UP=2, LEFT=3.
  - base codes.
  - FSM state enum.
  - a saturating-add helper function.
- Sub-module sw_cell: combinational. Inputs are the diag/up/left neighbour scores, two bases and the three scoring values; outputs are the score and dir. It is instantiated once in the FILL datapath.
- The top level owns the FSM, the two row buffers (previous/current), the REF_LEN*QUERY_LEN x 2-bit direction memory, the max tracker and the traceback.

Test Plan:
1. R=Q=4, scores (3,-1,-2), ref ACGT, query ACGT -> max_score 12, end (4,4), L=4, masks 0, pairs k0..3 = T,G,C,A both sides, result_valid at T+22.
2. R=Q=4, scores (5,-5,-1), ref ACGT, query ACTA -> max_score 14, end (4,3), L=4. Ref pairs T,G,C,A; query pairs T,gap,C,A; query_gap_mask=4'b0010; ref_gap_mask=0.
3. R=Q=4, scores (3,-1,-2), ref AAAA, query TTTT -> max_score 0, L=0, ref_end=query_end=0, all vectors 0, result_valid at T+18.
4. R=Q=4, SCORE_W=5, scores (7,-1,-2), ref ACGT, query ACGT -> diagonal 7,14,15,15 (saturated), max_score 15, end (3,3) (first maximum), L=3.
5. Case 1 with result_ready held low 10 cycles and start_valid pulsed during FILL and DONE -> outputs stable, start_ready=0, extra starts ignored; one accept returns to IDLE.
6. rst asserted for 1 cycle mid-FILL of case 2, then case 1 started -> all outputs 0 the cycle after rst, and the case 1 result is exact.

Source files
------------

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared codes, FSM state type and the saturating-add helper
//                for the Smith-Waterman alignment engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    // Traceback direction codes stored per score cell
    localparam logic [1:0] DIR_STOP = 2'd0;
    localparam logic [1:0] DIR_DIAG = 2'd1;
    localparam logic [1:0] DIR_UP   = 2'd2;
    localparam logic [1:0] DIR_LEFT = 2'd3;

    // Nucleotide encodings
    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_T = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_C = 2'b11;

    // Engine control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_TRACE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    // Signed add clamped at an upper limit. Negative results are passed
    // through untouched because the cell floors them at zero anyway.
    function automatic int sat_add(input int a, input int b, input int limit);
        int s;
        s = a + b;
        if (s > limit) begin
            s = limit;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_cell.sv
`default_nettype none
// ============================================================================
//  Module      : sw_cell
//  Description : Combinational Smith-Waterman score cell. Picks the best of
//                the diagonal / up / left candidates (diagonal preferred on
//                ties, then up) and floors non-positive results to STOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_cell
    import sw_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int BASE_WIDTH = 2
) (
    input  logic        [SCORE_W-1:0]    diag_i,
    input  logic        [SCORE_W-1:0]    up_i,
    input  logic        [SCORE_W-1:0]    left_i,
    input  logic        [BASE_WIDTH-1:0] ref_base_i,
    input  logic        [BASE_WIDTH-1:0] query_base_i,
    input  logic signed [SCORE_W-1:0]    match_i,
    input  logic signed [SCORE_W-1:0]    mismatch_i,
    input  logic signed [SCORE_W-1:0]    gap_i,
    output logic        [SCORE_W-1:0]    score_o,
    output logic        [1:0]            dir_o
);

    localparam int LIMIT = (1 << (SCORE_W - 1)) - 1;
    localparam int CW    = SCORE_W + 2;

    logic signed [CW-1:0] w_diag;
    logic signed [CW-1:0] w_up;
    logic signed [CW-1:0] w_left;
    logic signed [CW-1:0] w_best;
    logic        [1:0]    w_dir;

    // Candidate scores and the strictly-greater selection chain
    always_comb begin
        w_diag = CW'(sat_add(int'(diag_i),
                             (ref_base_i == query_base_i) ? int'(match_i) : int'(mismatch_i),
                             LIMIT));
        w_up   = CW'(sat_add(int'(up_i),   int'(gap_i), LIMIT));
        w_left = CW'(sat_add(int'(left_i), int'(gap_i), LIMIT));

        w_best = w_diag;
        w_dir  = DIR_DIAG;
        if (w_up > w_best) begin
            w_best = w_up;
            w_dir  = DIR_UP;
        end
        if (w_left > w_best) begin
            w_best = w_left;
            w_dir  = DIR_LEFT;
        end
        if (w_best <= 0) begin
            w_best = '0;
            w_dir  = DIR_STOP;
        end

        score_o = w_best[SCORE_W-1:0];
        dir_o   = w_dir;
    end

endmodule
`default_nettype wire

// File: rtl/sw_align_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sw_align_engine
//  Description : Multi-cycle Smith-Waterman local aligner. Fills the score
//                matrix one cell per cycle using two row buffers, keeps only
//                2-bit traceback directions, then walks back one pair per
//                cycle and holds the result behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_align_engine
    import sw_pkg::*;
#(
    parameter int REF_LEN    = 15,
    parameter int QUERY_LEN  = 10,
    parameter int BASE_WIDTH = 2,
    parameter int SCORE_W    = 8,
    parameter int ALIGN_LEN  = REF_LEN + QUERY_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [REF_LEN*BASE_WIDTH-1:0]   ref_seq,
    input  logic [QUERY_LEN*BASE_WIDTH-1:0] query_seq,
    input  logic signed [SCORE_W-1:0]       match_score,
    input  logic signed [SCORE_W-1:0]       mismatch_score,
    input  logic signed [SCORE_W-1:0]       gap_score,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [ALIGN_LEN*BASE_WIDTH-1:0] aligned_ref_seq,
    output logic [ALIGN_LEN*BASE_WIDTH-1:0] aligned_query_seq,
    output logic [ALIGN_LEN-1:0]            ref_gap_mask,
    output logic [ALIGN_LEN-1:0]            query_gap_mask,
    output logic [7:0]                      alignment_length,
    output logic [SCORE_W-1:0]              max_score,
    output logic [7:0]                      ref_end,
    output logic [7:0]                      query_end,
    output logic                            busy
);

    localparam int CELLS   = REF_LEN * QUERY_LEN;
    localparam int DIR_AW  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int REF_AW  = $clog2(REF_LEN * BASE_WIDTH);
    localparam int QRY_AW  = $clog2(QUERY_LEN * BASE_WIDTH);
    localparam int ALN_AW  = $clog2(ALIGN_LEN * BASE_WIDTH);
    localparam int MSK_AW  = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;
    localparam int ROW_AW  = $clog2(QUERY_LEN + 1);
    localparam logic [7:0] REF_LEN_B   = 8'(REF_LEN);
    localparam logic [7:0] QUERY_LEN_B = 8'(QUERY_LEN);
    localparam logic [7:0] ALIGN_LEN_B = 8'(ALIGN_LEN);

    // Control and job registers
    sw_state_e                        state_q;
    logic                             start_ready_q;
    logic                             busy_q;
    logic                             result_valid_q;
    logic [REF_LEN*BASE_WIDTH-1:0]    ref_q;
    logic [QUERY_LEN*BASE_WIDTH-1:0]  query_q;
    logic signed [SCORE_W-1:0]        match_q;
    logic signed [SCORE_W-1:0]        mismatch_q;
    logic signed [SCORE_W-1:0]        gap_q;

    // Fill datapath: two score rows (index 0 is the constant-zero column)
    logic [SCORE_W-1:0]               prev_row_q [0:QUERY_LEN];
    logic [SCORE_W-1:0]               cur_row_q  [0:QUERY_LEN];
    logic [1:0]                       dir_mem_q  [0:CELLS-1];
    logic [7:0]                       fi_q;
    logic [7:0]                       fj_q;

    // Traceback pointer and result registers
    logic [7:0]                       ti_q;
    logic [7:0]                       tj_q;
    logic [SCORE_W-1:0]               max_q;
    logic [7:0]                       ref_end_q;
    logic [7:0]                       query_end_q;
    logic [7:0]                       len_q;
    logic [ALIGN_LEN*BASE_WIDTH-1:0]  aref_q;
    logic [ALIGN_LEN*BASE_WIDTH-1:0]  aqry_q;
    logic [ALIGN_LEN-1:0]             rmask_q;
    logic [ALIGN_LEN-1:0]             qmask_q;

    // Combinational helpers
    logic [REF_AW-1:0]                w_fill_ref_off;
    logic [QRY_AW-1:0]                w_fill_qry_off;
    logic [DIR_AW-1:0]                w_fill_addr;
    logic [ROW_AW-1:0]                w_col;
    logic [ROW_AW-1:0]                w_col_m1;
    logic [SCORE_W-1:0]               w_cell_score;
    logic [1:0]                       w_cell_dir;
    logic                             w_new_max;
    logic [REF_AW-1:0]                w_tr_ref_off;
    logic [QRY_AW-1:0]                w_tr_qry_off;
    logic [DIR_AW-1:0]                w_tr_addr;
    logic [1:0]                       w_tr_dir;
    logic                             w_tr_stop;
    logic [ALN_AW-1:0]                w_aln_off;
    logic [MSK_AW-1:0]                w_msk_idx;
    logic [BASE_WIDTH-1:0]            w_tr_ref_base;
    logic [BASE_WIDTH-1:0]            w_tr_qry_base;

    // Addressing for the cell being filled; base 0 lives at the MSBs
    always_comb begin
        w_fill_ref_off = REF_AW'((REF_LEN - int'(fi_q)) * BASE_WIDTH);
        w_fill_qry_off = QRY_AW'((QUERY_LEN - int'(fj_q)) * BASE_WIDTH);
        w_fill_addr    = DIR_AW'((int'(fi_q) - 1) * QUERY_LEN + int'(fj_q) - 1);
        w_col          = ROW_AW'(fj_q);
        w_col_m1       = ROW_AW'(int'(fj_q) - 1);
    end

    sw_cell #(
        .SCORE_W    (SCORE_W),
        .BASE_WIDTH (BASE_WIDTH)
    ) u_cell (
        .diag_i       (prev_row_q[w_col_m1]),
        .up_i         (prev_row_q[w_col]),
        .left_i       (cur_row_q[w_col_m1]),
        .ref_base_i   (ref_q[w_fill_ref_off +: BASE_WIDTH]),
        .query_base_i (query_q[w_fill_qry_off +: BASE_WIDTH]),
        .match_i      (match_q),
        .mismatch_i   (mismatch_q),
        .gap_i        (gap_q),
        .score_o      (w_cell_score),
        .dir_o        (w_cell_dir)
    );

    // Only a strictly larger score moves the maximum, so the earliest cell wins ties
    assign w_new_max = (w_cell_score > max_q);

    // Traceback view of the current pointer; row/column 0 reads as STOP
    always_comb begin
        w_tr_ref_off  = (ti_q == 8'd0) ? '0 : REF_AW'((REF_LEN - int'(ti_q)) * BASE_WIDTH);
        w_tr_qry_off  = (tj_q == 8'd0) ? '0 : QRY_AW'((QUERY_LEN - int'(tj_q)) * BASE_WIDTH);
        w_tr_addr     = DIR_AW'((int'(ti_q) - 1) * QUERY_LEN + int'(tj_q) - 1);
        w_tr_dir      = ((ti_q == 8'd0) || (tj_q == 8'd0)) ? DIR_STOP : dir_mem_q[w_tr_addr];
        w_tr_stop     = (w_tr_dir == DIR_STOP) || (len_q == ALIGN_LEN_B);
        w_aln_off     = ALN_AW'(int'(len_q) * BASE_WIDTH);
        w_msk_idx     = MSK_AW'(len_q);
        w_tr_ref_base = ref_q[w_tr_ref_off +: BASE_WIDTH];
        w_tr_qry_base = query_q[w_tr_qry_off +: BASE_WIDTH];
    end

    // Direction memory written once per filled cell; it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ST_FILL)) begin
            dir_mem_q[w_fill_addr] <= w_cell_dir;
        end
    end

    // Main FSM: job latch, matrix fill, traceback and result handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            ref_q          <= '0;
            query_q        <= '0;
            match_q        <= '0;
            mismatch_q     <= '0;
            gap_q          <= '0;
            fi_q           <= 8'd1;
            fj_q           <= 8'd1;
            ti_q           <= 8'd0;
            tj_q           <= 8'd0;
            max_q          <= '0;
            ref_end_q      <= 8'd0;
            query_end_q    <= 8'd0;
            len_q          <= 8'd0;
            aref_q         <= '0;
            aqry_q         <= '0;
            rmask_q        <= '0;
            qmask_q        <= '0;
            for (int k = 0; k <= QUERY_LEN; k++) begin
                prev_row_q[k] <= '0;
                cur_row_q[k]  <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        ref_q         <= ref_seq;
                        query_q       <= query_seq;
                        match_q       <= match_score;
                        mismatch_q    <= mismatch_score;
                        gap_q         <= gap_score;
                        fi_q          <= 8'd1;
                        fj_q          <= 8'd1;
                        max_q         <= '0;
                        ref_end_q     <= 8'd0;
                        query_end_q   <= 8'd0;
                        len_q         <= 8'd0;
                        aref_q        <= '0;
                        aqry_q        <= '0;
                        rmask_q       <= '0;
                        qmask_q       <= '0;
                        for (int k = 0; k <= QUERY_LEN; k++) begin
                            prev_row_q[k] <= '0;
                            cur_row_q[k]  <= '0;
                        end
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    cur_row_q[w_col] <= w_cell_score;
                    if (w_new_max) begin
                        max_q       <= w_cell_score;
                        ref_end_q   <= fi_q;
                        query_end_q <= fj_q;
                    end
                    if (fj_q == QUERY_LEN_B) begin
                        // Completed row becomes the previous row for the next one
                        for (int k = 1; k < QUERY_LEN; k++) begin
                            prev_row_q[k] <= cur_row_q[k];
                        end
                        prev_row_q[QUERY_LEN] <= w_cell_score;
                        fj_q <= 8'd1;
                        if (fi_q == REF_LEN_B) begin
                            ti_q    <= w_new_max ? fi_q : ref_end_q;
                            tj_q    <= w_new_max ? fj_q : query_end_q;
                            state_q <= ST_TRACE;
                        end else begin
                            fi_q <= fi_q + 8'd1;
                        end
                    end else begin
                        fj_q <= fj_q + 8'd1;
                    end
                end

                ST_TRACE: begin
                    if (w_tr_stop) begin
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end else begin
                        len_q <= len_q + 8'd1;
                        case (w_tr_dir)
                            DIR_DIAG: begin
                                aref_q[w_aln_off +: BASE_WIDTH] <= w_tr_ref_base;
                                aqry_q[w_aln_off +: BASE_WIDTH] <= w_tr_qry_base;
                                ti_q <= ti_q - 8'd1;
                                tj_q <= tj_q - 8'd1;
                            end
                            DIR_UP: begin
                                aref_q[w_aln_off +: BASE_WIDTH] <= w_tr_ref_base;
                                qmask_q[w_msk_idx]              <= 1'b1;
                                ti_q <= ti_q - 8'd1;
                            end
                            default: begin
                                rmask_q[w_msk_idx]              <= 1'b1;
                                aqry_q[w_aln_off +: BASE_WIDTH] <= w_tr_qry_base;
                                tj_q <= tj_q - 8'd1;
                            end
                        endcase
                    end
                end

                ST_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        start_ready_q  <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready       = start_ready_q;
    assign busy              = busy_q;
    assign result_valid      = result_valid_q;
    assign aligned_ref_seq   = aref_q;
    assign aligned_query_seq = aqry_q;
    assign ref_gap_mask      = rmask_q;
    assign query_gap_mask    = qmask_q;
    assign alignment_length  = len_q;
    assign max_score         = max_q;
    assign ref_end           = ref_end_q;
    assign query_end         = query_end_q;

endmodule
`default_nettype wire

// File: tb/tb_sw_align_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_align_engine
//  Description : Directed self-checking bench for sw_align_engine using two
//                4x4 instances (8-bit and 5-bit scores).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_align_engine;

    localparam int R  = 4;
    localparam int Q  = 4;
    localparam int AL = R + Q;

    // A=00 T=01 G=10 C=11, base 0 at MSBs
    localparam logic [7:0] S_ACGT = 8'h39;
    localparam logic [7:0] S_ACTA = 8'h34;
    localparam logic [7:0] S_AAAA = 8'h00;
    localparam logic [7:0] S_TTTT = 8'h55;

    logic clk = 1'b0;
    logic rst;

    logic               start_valid, start_ready, result_valid, result_ready, busy;
    logic [2*R-1:0]     ref_seq;
    logic [2*Q-1:0]     query_seq;
    logic signed [7:0]  match_s, mismatch_s, gap_s;
    logic [2*AL-1:0]    aref, aqry;
    logic [AL-1:0]      rmask, qmask;
    logic [7:0]         alen, rend, qend;
    logic [7:0]         maxs;

    logic               f_start_valid, f_start_ready, f_result_valid, f_result_ready, f_busy;
    logic [2*R-1:0]     f_ref_seq;
    logic [2*Q-1:0]     f_query_seq;
    logic signed [4:0]  f_match_s, f_mismatch_s, f_gap_s;
    logic [2*AL-1:0]    f_aref, f_aqry;
    logic [AL-1:0]      f_rmask, f_qmask;
    logic [7:0]         f_alen, f_rend, f_qend;
    logic [4:0]         f_maxs;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sw_align_engine #(.REF_LEN(R), .QUERY_LEN(Q), .BASE_WIDTH(2), .SCORE_W(8), .ALIGN_LEN(AL)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .ref_seq(ref_seq), .query_seq(query_seq),
        .match_score(match_s), .mismatch_score(mismatch_s), .gap_score(gap_s),
        .result_valid(result_valid), .result_ready(result_ready),
        .aligned_ref_seq(aref), .aligned_query_seq(aqry),
        .ref_gap_mask(rmask), .query_gap_mask(qmask),
        .alignment_length(alen), .max_score(maxs),
        .ref_end(rend), .query_end(qend), .busy(busy)
    );

    sw_align_engine #(.REF_LEN(R), .QUERY_LEN(Q), .BASE_WIDTH(2), .SCORE_W(5), .ALIGN_LEN(AL)) dut5 (
        .clk(clk), .rst(rst), .start_valid(f_start_valid), .start_ready(f_start_ready),
        .ref_seq(f_ref_seq), .query_seq(f_query_seq),
        .match_score(f_match_s), .mismatch_score(f_mismatch_s), .gap_score(f_gap_s),
        .result_valid(f_result_valid), .result_ready(f_result_ready),
        .aligned_ref_seq(f_aref), .aligned_query_seq(f_aqry),
        .ref_gap_mask(f_rmask), .query_gap_mask(f_qmask),
        .alignment_length(f_alen), .max_score(f_maxs),
        .ref_end(f_rend), .query_end(f_qend), .busy(f_busy)
    );

    // Drive a job; the accepting edge is the next posedge. Returns #1 after it.
    task automatic start_job(input logic [7:0] r, input logic [7:0] q,
                             input logic signed [7:0] m, input logic signed [7:0] mm,
                             input logic signed [7:0] g);
        ref_seq     = r;
        query_seq   = q;
        match_s     = m;
        mismatch_s  = mm;
        gap_s       = g;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Latency in cycles counted from the accept cycle T; bounded by a budget
    task automatic wait_result(output int lat);
        lat = 1;
        while (result_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept_result;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_valid = 1'b0; result_ready = 1'b0;
        f_start_valid = 1'b0; f_result_ready = 1'b0;
        ref_seq = '0; query_seq = '0; match_s = '0; mismatch_s = '0; gap_s = '0;
        f_ref_seq = '0; f_query_seq = '0; f_match_s = '0; f_mismatch_s = '0; f_gap_s = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready got %b want 1", start_ready); else passed++;
        total++; if ({busy, result_valid} !== 2'b00) $display("FAIL reset_busy_valid got %b want 00", {busy, result_valid}); else passed++;
        total++; if ({maxs, alen, rend, qend} !== 32'h0) $display("FAIL reset_scores got %h want 0", {maxs, alen, rend, qend}); else passed++;
        total++; if ({aref, aqry, rmask, qmask} !== '0) $display("FAIL reset_vectors got %h want 0", {aref, aqry, rmask, qmask}); else passed++;
        total++; if ({f_start_ready, f_busy, f_result_valid} !== 3'b100) $display("FAIL reset_dut5 got %b want 100", {f_start_ready, f_busy, f_result_valid}); else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_exact_match;
        int lat;
        start_job(S_ACGT, S_ACGT, 8'sd3, -8'sd1, -8'sd2);
        total++; if ({busy, start_ready} !== 2'b10) $display("FAIL c1_busy_ready got %b want 10", {busy, start_ready}); else passed++;
        wait_result(lat);
        total++; if (lat !== 22) $display("FAIL c1_latency got %0d want 22", lat); else passed++;
        total++; if (maxs !== 8'd12) $display("FAIL c1_max got %0d want 12", maxs); else passed++;
        total++; if ({rend, qend} !== {8'd4, 8'd4}) $display("FAIL c1_end got %0d,%0d want 4,4", rend, qend); else passed++;
        total++; if (alen !== 8'd4) $display("FAIL c1_len got %0d want 4", alen); else passed++;
        total++; if ({aref, aqry} !== {16'h0039, 16'h0039}) $display("FAIL c1_pairs got %h %h want 0039 0039", aref, aqry); else passed++;
        total++; if ({rmask, qmask} !== 16'h0) $display("FAIL c1_masks got %h %h want 00 00", rmask, qmask); else passed++;
        total++; if ({busy, start_ready} !== 2'b00) $display("FAIL c1_done_flags got %b want 00", {busy, start_ready}); else passed++;
        accept_result();
        total++; if ({result_valid, start_ready} !== 2'b01) $display("FAIL c1_accept got %b want 01", {result_valid, start_ready}); else passed++;
        total++; if (maxs !== 8'd12) $display("FAIL c1_held_after_accept got %0d want 12", maxs); else passed++;
    endtask

    task automatic test_gap;
        int lat;
        start_job(S_ACGT, S_ACTA, 8'sd5, -8'sd5, -8'sd1);
        wait_result(lat);
        total++; if (lat !== 22) $display("FAIL c2_latency got %0d want 22", lat); else passed++;
        total++; if (maxs !== 8'd14) $display("FAIL c2_max got %0d want 14", maxs); else passed++;
        total++; if ({rend, qend} !== {8'd4, 8'd3}) $display("FAIL c2_end got %0d,%0d want 4,3", rend, qend); else passed++;
        total++; if (alen !== 8'd4) $display("FAIL c2_len got %0d want 4", alen); else passed++;
        total++; if (aref !== 16'h0039) $display("FAIL c2_ref_pairs got %h want 0039", aref); else passed++;
        total++; if (aqry !== 16'h0031) $display("FAIL c2_query_pairs got %h want 0031", aqry); else passed++;
        total++; if (qmask !== 8'h02) $display("FAIL c2_query_gap_mask got %h want 02", qmask); else passed++;
        total++; if (rmask !== 8'h00) $display("FAIL c2_ref_gap_mask got %h want 00", rmask); else passed++;
        accept_result();
    endtask

    task automatic test_no_match;
        int lat;
        start_job(S_AAAA, S_TTTT, 8'sd3, -8'sd1, -8'sd2);
        wait_result(lat);
        total++; if (lat !== 18) $display("FAIL c3_latency got %0d want 18", lat); else passed++;
        total++; if ({maxs, alen, rend, qend} !== 32'h0) $display("FAIL c3_scores got %h want 0", {maxs, alen, rend, qend}); else passed++;
        total++; if ({aref, aqry, rmask, qmask} !== '0) $display("FAIL c3_vectors got %h want 0", {aref, aqry, rmask, qmask}); else passed++;
        accept_result();
    endtask

    task automatic test_saturation;
        int lat;
        f_ref_seq = S_ACGT; f_query_seq = S_ACGT;
        f_match_s = 5'sd7; f_mismatch_s = -5'sd1; f_gap_s = -5'sd2;
        f_start_valid = 1'b1;
        @(posedge clk);
        #1;
        f_start_valid = 1'b0;
        lat = 1;
        while (f_result_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat !== 21) $display("FAIL c4_latency got %0d want 21", lat); else passed++;
        total++; if (f_maxs !== 5'd15) $display("FAIL c4_max got %0d want 15", f_maxs); else passed++;
        total++; if ({f_rend, f_qend} !== {8'd3, 8'd3}) $display("FAIL c4_end got %0d,%0d want 3,3", f_rend, f_qend); else passed++;
        total++; if (f_alen !== 8'd3) $display("FAIL c4_len got %0d want 3", f_alen); else passed++;
        total++; if ({f_aref, f_aqry} !== {16'h000E, 16'h000E}) $display("FAIL c4_pairs got %h %h want 000e 000e", f_aref, f_aqry); else passed++;
        total++; if ({f_rmask, f_qmask} !== 16'h0) $display("FAIL c4_masks got %h %h want 00 00", f_rmask, f_qmask); else passed++;
        f_result_ready = 1'b1;
        @(posedge clk);
        #1;
        f_result_ready = 1'b0;
        total++; if ({f_result_valid, f_start_ready} !== 2'b01) $display("FAIL c4_accept got %b want 01", {f_result_valid, f_start_ready}); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        int bad;
        start_job(S_ACGT, S_ACGT, 8'sd3, -8'sd1, -8'sd2);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        total++; if (start_ready !== 1'b0) $display("FAIL c5_ready_in_fill got %b want 0", start_ready); else passed++;
        // New data and a stray start mid-fill must not disturb the latched job
        ref_seq = S_AAAA; query_seq = S_TTTT; match_s = -8'sd4;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_result(lat);
        total++; if (lat + 5 !== 22) $display("FAIL c5_latency got %0d want 22", lat + 5); else passed++;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) start_valid = 1'b1;
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            if ({result_valid, start_ready, maxs, alen, aref, aqry} !== {1'b1, 1'b0, 8'd12, 8'd4, 16'h0039, 16'h0039}) bad++;
        end
        total++; if (bad !== 0) $display("FAIL c5_stable_while_stalled got %0d bad cycles want 0", bad); else passed++;
        accept_result();
        total++; if ({result_valid, start_ready} !== 2'b01) $display("FAIL c5_accept got %b want 01", {result_valid, start_ready}); else passed++;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++; if ({busy, start_ready} !== 2'b01) $display("FAIL c5_no_queued_start got %b want 01", {busy, start_ready}); else passed++;
        total++; if ({maxs, alen} !== {8'd12, 8'd4}) $display("FAIL c5_result_visible got %h want 0c04", {maxs, alen}); else passed++;
    endtask

    task automatic test_reset_mid_fill;
        int lat;
        start_job(S_ACGT, S_ACTA, 8'sd5, -8'sd5, -8'sd1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if ({start_ready, busy, result_valid} !== 3'b100) $display("FAIL c6_flags_after_rst got %b want 100", {start_ready, busy, result_valid}); else passed++;
        total++; if ({maxs, alen, rend, qend} !== 32'h0) $display("FAIL c6_scores_after_rst got %h want 0", {maxs, alen, rend, qend}); else passed++;
        total++; if ({aref, aqry, rmask, qmask} !== '0) $display("FAIL c6_vectors_after_rst got %h want 0", {aref, aqry, rmask, qmask}); else passed++;
        start_job(S_ACGT, S_ACGT, 8'sd3, -8'sd1, -8'sd2);
        wait_result(lat);
        total++; if (lat !== 22) $display("FAIL c6_latency got %0d want 22", lat); else passed++;
        total++; if ({maxs, rend, qend, alen} !== {8'd12, 8'd4, 8'd4, 8'd4}) $display("FAIL c6_scores got %h want 0c040404", {maxs, rend, qend, alen}); else passed++;
        total++; if ({aref, aqry, rmask, qmask} !== {16'h0039, 16'h0039, 16'h0000}) $display("FAIL c6_vectors got %h want 0039003900", {aref, aqry, rmask, qmask}); else passed++;
        accept_result();
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_gap();
        test_no_match();
        test_saturation();
        test_back_to_back();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
